// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: mode and state encodings shared by run control, UI logic and time-keeping counters
// Contents: mode_e (UI mode codes), state_e (sequencer states), mode_to_state() (reserved code folds to PAUSE)
package clock_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_PAUSE = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_FAST  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAST  = 2'b10,
    ST_STEP  = 2'b11
  } state_e;
  function automatic state_e mode_to_state(input logic [1:0] m);
    return m == MODE_RUN ? ST_RUN : m == MODE_FAST ? ST_FAST : ST_PAUSE;
  endfunction
  function automatic logic is_running(input state_e s);
    return s == ST_RUN || s == ST_FAST;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running counter that wraps to zero after reaching limit
// Ports: clk, reset (sync, active-high), en (count), clr (force zero), limit (last count value), wrap (count==limit while enabled)
module tick_prescaler #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         wrap
);
  logic [W-1:0] cnt;
  assign wrap = en && cnt == limit;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clock_rate_ctrl.sv
// clock_rate_ctrl: run-control sequencer for the 1 Hz tick (pause / run / fast-forward / single step)
// Ports: clk, reset (sync, active-high), mode_valid/mode/mode_ready (mode write handshake),
//        step_req/step_ack (single-step request and its pulse), tick (one-cycle enable),
//        usr_clk (toggles per tick), running (RUN or FAST)
module clock_rate_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int          DIV_NORMAL = 25000000,
  parameter int          DIV_FAST   = 250000,
  parameter int          CNT_W      = 25,
  parameter logic [1:0]  RESET_MODE = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_valid,
  input  logic [1:0] mode,
  output logic       mode_ready,
  input  logic       step_req,
  output logic       step_ack,
  output logic       tick,
  output logic       usr_clk,
  output logic       running
);
  localparam state_e RST_ST = mode_to_state(RESET_MODE);
  state_e     state, nxt, req_st;
  logic       accept, change, wrap, fire;
  logic [CNT_W-1:0] limit;
  always_comb begin
    req_st = mode_to_state(mode);
    accept = mode_valid && mode_ready;
    // only a write that actually changes mode restarts the prescaler; same-mode writes keep phase
    change = accept && req_st != state;
    nxt    = change ? req_st :
             state == ST_STEP ? ST_PAUSE :
             (state == ST_PAUSE && step_req && !accept) ? ST_STEP : state;
    limit  = state == ST_FAST ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_NORMAL - 1);
    fire   = wrap || state == ST_STEP;
  end
  tick_prescaler #(.W(CNT_W)) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (is_running(state) && !change),
    .clr  (change),
    .limit(limit),
    .wrap (wrap)
  );
  // mode_ready/running are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk)
    if (reset) begin
      state      <= RST_ST;
      tick       <= 1'b0;
      step_ack   <= 1'b0;
      usr_clk    <= 1'b0;
      mode_ready <= 1'b1;
      running    <= is_running(RST_ST);
    end else begin
      state      <= nxt;
      tick       <= fire;
      step_ack   <= state == ST_STEP;
      usr_clk    <= usr_clk ^ fire;
      mode_ready <= nxt != ST_STEP;
      running    <= is_running(nxt);
    end
endmodule

// File: tb/tb_clock_rate_ctrl.sv
// tb_clock_rate_ctrl: scoreboard bench; a behavioural model queues expected outputs per edge, compared after the edge
module tb_clock_rate_ctrl;
  typedef struct packed {
    logic tick, step_ack, usr_clk, running, mode_ready;
  } exp_t;
  logic clk = 0, reset = 1, mode_valid = 0, step_req = 0;
  logic [1:0] mode = 0;
  logic mode_ready, step_ack, tick, usr_clk, running;
  int total = 0, bad = 0, ticks = 0, acks = 0, base_t, base_a;
  exp_t q[$];
  int m_st = 1, m_cnt = 0;
  logic m_usr = 0;
  always #5 clk = ~clk;
  clock_rate_ctrl #(.DIV_NORMAL(10), .DIV_FAST(3), .CNT_W(25), .RESET_MODE(2'b01)) dut (
    .clk(clk), .reset(reset), .mode_valid(mode_valid), .mode(mode), .mode_ready(mode_ready),
    .step_req(step_req), .step_ack(step_ack), .tick(tick), .usr_clk(usr_clk), .running(running)
  );
  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask
  // model: states 0 pause, 1 run, 2 fast, 3 step
  task automatic model_push();
    exp_t e;
    logic t = 0, a = 0, acc;
    int nm, div;
    if (reset) begin
      m_st = 1; m_cnt = 0; m_usr = 0;
    end else begin
      acc = mode_valid && m_st != 3;
      nm = mode == 2'b01 ? 1 : mode == 2'b10 ? 2 : 0;
      if (acc && nm != m_st) begin
        m_st = nm; m_cnt = 0;
      end else if (m_st == 3) begin
        t = 1; a = 1; m_usr = ~m_usr; m_st = 0;
      end else if (m_st == 0) begin
        if (step_req && !acc) m_st = 3;
      end else begin
        div = m_st == 1 ? 10 : 3;
        if (m_cnt == div - 1) begin
          m_cnt = 0; t = 1; m_usr = ~m_usr;
        end else m_cnt++;
      end
    end
    e.tick = t; e.step_ack = a; e.usr_clk = m_usr;
    e.running = m_st == 1 || m_st == 2; e.mode_ready = m_st != 3;
    q.push_back(e);
  endtask
  task automatic cyc();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("tick", int'(tick), int'(e.tick));
    chk("step_ack", int'(step_ack), int'(e.step_ack));
    chk("usr_clk", int'(usr_clk), int'(e.usr_clk));
    chk("running", int'(running), int'(e.running));
    chk("mode_ready", int'(mode_ready), int'(e.mode_ready));
    ticks += int'(tick === 1'b1);
    acks += int'(step_ack === 1'b1);
  endtask
  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask
  task automatic write_mode(input logic [1:0] m);
    mode_valid = 1; mode = m;
    cyc();
    mode_valid = 0;
  endtask
  task automatic wait_cnt(input int c);
    int n = 0;
    while (m_cnt != c && n < 40) begin
      cyc(); n++;
    end
    chk("wait_cnt_timeout", int'(m_cnt == c), 1);
  endtask
  initial begin
    cycles(3);
    chk("reset_ready", int'(mode_ready), 1);
    chk("reset_tick", int'(tick), 0);
    reset = 0;
    base_t = ticks;
    cycles(9);
    chk("no_tick_before_10", ticks - base_t, 0);
    cyc();
    chk("first_tick_at_10", int'(tick), 1);
    cycles(25);
    chk("run_ticks_35", ticks - base_t, 3);
    wait_cnt(6);
    write_mode(2'b10);
    base_t = ticks;
    cycles(9);
    chk("fast_ticks_9", ticks - base_t, 3);
    wait_cnt(1);
    write_mode(2'b10);
    cycles(10);
    write_mode(2'b00);
    base_t = ticks;
    cycles(50);
    chk("pause_ticks", ticks - base_t, 0);
    base_a = acks;
    step_req = 1;
    cyc();
    step_req = 0;
    cycles(4);
    chk("single_step_ticks", ticks - base_t, 1);
    chk("single_step_acks", acks - base_a, 1);
    base_a = acks;
    step_req = 1;
    cycles(8);
    step_req = 0;
    cycles(3);
    chk("held_step_acks", acks - base_a, 4);
    base_a = acks;
    step_req = 1; mode_valid = 1; mode = 2'b01;
    cyc();
    step_req = 0; mode_valid = 0;
    cycles(3);
    chk("write_beats_step", acks - base_a, 0);
    chk("run_after_write", int'(running), 1);
    base_a = acks;
    step_req = 1;
    cycles(25);
    step_req = 0;
    chk("step_in_run_ignored", acks - base_a, 0);
    write_mode(2'b11);
    base_t = ticks;
    cycles(20);
    chk("rsvd_is_pause", ticks - base_t, 0);
    chk("rsvd_not_running", int'(running), 0);
    step_req = 1;
    cyc();
    reset = 1;
    cyc();
    step_req = 0;
    reset = 0;
    cycles(2);
    wait_cnt(9);
    reset = 1;
    cyc();
    reset = 0;
    base_t = ticks;
    cycles(25);
    chk("restart_ticks", ticks - base_t, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
